// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: head entry of the fetch FIFO and decode's ready.
// The fetch unit drives the master side; decode sits on the slave side.
interface fetch_unit_if;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic        id_fault;

    modport master (
        output id_valid,
        output id_pc,
        output id_inst,
        output id_fault,
        input  id_ready
    );

    modport slave (
        input  id_valid,
        input  id_pc,
        input  id_inst,
        input  id_fault,
        output id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register driving a combinational instruction memory, feeding a
// small {pc, inst, fault} FIFO toward decode. Optional fault tagging under `FETCH_FAULT_EN.
module fetch_unit #(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int          DEPTH          = 2,
    parameter int          IMEM_ADDR_BITS = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    input  logic          redirect_valid,
    input  logic [63:0]   redirect_pc,
    output logic [63:0]   im_addr,
    input  logic [31:0]   im_dout,
    fetch_unit_if.master  id
);

    localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IMEM_ADDR_BITS < 2 || IMEM_ADDR_BITS > 64)
    begin : g_cfg_check
        $error("fetch_unit: DEPTH must be a power of two >= 2, IMEM_ADDR_BITS in 2..64");
    end

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } fill_state_t;

    // Fetch stage (p0): program counter
    logic [63:0]      pc_p0;

    // FIFO stage (p1): entry storage and control
    logic [63:0]      ent_pc_p1   [DEPTH];
    logic [31:0]      ent_inst_p1 [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    fill_state_t      fill_state;
    logic             vld_p1;
    logic             pop;
    logic             space;
    logic             push;
    logic [31:0]      push_inst;

    // Occupancy state is a view of count, not a separate register.
    always_comb begin
        fill_state = S_PARTIAL;
        if (count == '0)
            fill_state = S_EMPTY;
        else if (count == CNT_W'(DEPTH))
            fill_state = S_FULL;
    end

    assign vld_p1 = (fill_state != S_EMPTY);
    assign pop    = vld_p1 & id.id_ready;
    assign space  = (fill_state != S_FULL) | pop;
    assign push   = fetch_en & space & ~redirect_valid & ~rst;

    assign im_addr = pc_p0;

`ifdef FETCH_FAULT_EN
    logic ent_fault_p1 [DEPTH];
    logic push_fault;

    function automatic logic addr_fault(input logic [63:0] addr);
        addr_fault = (addr[1:0] != 2'b00) | ((addr >> IMEM_ADDR_BITS) != 64'd0);
    endfunction

    assign push_fault = addr_fault(pc_p0);
    // A faulting fetch still occupies a slot so execute sees the trap in program order.
    assign push_inst  = push_fault ? NOP : im_dout;

    always_ff @(posedge clk) begin
        if (push)
            ent_fault_p1[wr_ptr] <= push_fault;
    end

    assign id.id_fault = vld_p1 ? ent_fault_p1[rd_ptr] : 1'b0;
`else
    assign push_inst   = im_dout;
    assign id.id_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0  <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc_p0  <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_p0  <= pc_p0 + 64'd4;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload carries no reset; the empty-state output gating hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_pc_p1[wr_ptr]   <= pc_p0;
            ent_inst_p1[wr_ptr] <= push_inst;
        end
    end

    assign id.id_valid = vld_p1;
    assign id.id_pc    = vld_p1 ? ent_pc_p1[rd_ptr]   : 64'd0;
    assign id.id_inst  = vld_p1 ? ent_inst_p1[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the scripted scenarios, then randomized
// traffic against a queue-based reference model of the fetch FIFO.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_FAULT_EN
    localparam bit FAULT_BUILD = 1'b1;
`else
    localparam bit FAULT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] im_addr;
    logic [31:0] im_dout;

    fetch_unit_if ifc();

    fetch_unit #(
        .RESET_PC       (64'h0),
        .DEPTH          (DEPTH),
        .IMEM_ADDR_BITS (14)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_addr        (im_addr),
        .im_dout        (im_dout),
        .id             (ifc)
    );

    always #5 clk = ~clk;

    // 64-word memory image: word i is "addi x(i+1), x0, i" (mod register count).
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        int i;
        i = int'(a[7:2]);
        return 32'((i << 20) | (((i + 1) & 31) << 7) | 32'h13);
    endfunction

    function automatic logic [31:0] wi(input int i);
        return mem_word(64'(i) << 2);
    endfunction

    assign im_dout = mem_word(im_addr);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit r, input bit fe, input bit rv, input logic [63:0] rpc,
                         input bit rdy);
        rst            = r;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        ifc.id_ready   = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst, fe, rv;
        logic [63:0] rpc;
        bit          rdy;
        bit          e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        bit          e_fault;
        logic [63:0] e_im;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit fe, bit rv, logic [63:0] rpc, bit rdy,
                                bit ev, logic [63:0] epc, logic [31:0] ei, bit ef,
                                logic [63:0] eim);
        vec_t v;
        v.rst = r; v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_inst = ei; v.e_fault = ef; v.e_im = eim;
        return v;
    endfunction

    // Expected stored instruction for an address the fault rules flag.
    function automatic logic [31:0] fi(input logic [31:0] w);
        return FAULT_BUILD ? NOP : w;
    endfunction

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        bit          fault;
    } ent_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t        q[$];
        ent_t        e;
        logic [63:0] mpc;
        bit          r, fe, rv, rdy, pop, push, flt;
        logic [63:0] rpc;

        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        ifc.id_ready = 1'b0;

        // Streaming from reset
        vecs.push_back(mk(1,0,0,0,0,            0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,1,            1,64'h0,32'h00000093,0,64'h4));
        vecs.push_back(mk(0,1,0,0,1,            1,64'h4,32'h00100113,0,64'h8));
        vecs.push_back(mk(0,1,0,0,1,            1,64'h8,32'h00200193,0,64'hC));
        vecs.push_back(mk(0,1,0,0,1,            1,64'hC,32'h00300213,0,64'h10));
        // Backpressure fill, reset beating fetch_en
        vecs.push_back(mk(1,1,0,0,1,            0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,            1,64'h0,wi(0),0,64'h4));
        vecs.push_back(mk(0,1,0,0,0,            1,64'h0,wi(0),0,64'h8));
        vecs.push_back(mk(0,1,0,0,0,            1,64'h0,wi(0),0,64'h8));
        vecs.push_back(mk(0,1,0,0,0,            1,64'h0,wi(0),0,64'h8));
        vecs.push_back(mk(0,1,0,0,0,            1,64'h0,wi(0),0,64'h8));
        vecs.push_back(mk(0,1,0,0,1,            1,64'h4,wi(1),0,64'hC));
        vecs.push_back(mk(0,0,0,0,1,            1,64'h8,wi(2),0,64'hC));
        vecs.push_back(mk(0,0,0,0,1,            0,0,0,0,64'hC));
        // Redirect while full
        vecs.push_back(mk(0,1,0,0,0,            1,64'hC,wi(3),0,64'h10));
        vecs.push_back(mk(0,1,0,0,0,            1,64'hC,wi(3),0,64'h14));
        vecs.push_back(mk(0,1,1,64'h40,0,       0,0,0,0,64'h40));
        vecs.push_back(mk(0,1,0,0,1,            1,64'h40,wi(16),0,64'h44));
        // Redirect together with a pop
        vecs.push_back(mk(0,1,1,64'h80,1,       0,0,0,0,64'h80));
        vecs.push_back(mk(0,1,0,0,1,            1,64'h80,wi(32),0,64'h84));
        // fetch_en gap drains the FIFO, PC holds
        vecs.push_back(mk(0,0,0,0,1,            0,0,0,0,64'h84));
        vecs.push_back(mk(0,0,0,0,1,            0,0,0,0,64'h84));
        vecs.push_back(mk(0,0,0,0,1,            0,0,0,0,64'h84));
        vecs.push_back(mk(0,1,0,0,1,            1,64'h84,wi(33),0,64'h88));
        // Misaligned and out-of-range target, then a clean one
        vecs.push_back(mk(0,1,1,64'h4002,1,     0,0,0,0,64'h4002));
        vecs.push_back(mk(0,1,0,0,0,            1,64'h4002,fi(wi(0)),FAULT_BUILD,64'h4006));
        vecs.push_back(mk(0,1,1,64'h10,0,       0,0,0,0,64'h10));
        vecs.push_back(mk(0,1,0,0,0,            1,64'h10,wi(4),0,64'h14));
        // PC wrap at the top of the address space
        vecs.push_back(mk(0,1,1,64'hFFFF_FFFF_FFFF_FFFC,1, 0,0,0,0,64'hFFFF_FFFF_FFFF_FFFC));
        vecs.push_back(mk(0,1,0,0,1,            1,64'hFFFF_FFFF_FFFF_FFFC,fi(wi(63)),FAULT_BUILD,64'h0));
        vecs.push_back(mk(0,1,0,0,1,            1,64'h0,wi(0),0,64'h4));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), 64'(ifc.id_valid), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d_pc", i),    ifc.id_pc,         vecs[i].e_pc);
            check($sformatf("vec%0d_inst", i),  64'(ifc.id_inst),  64'(vecs[i].e_inst));
            check($sformatf("vec%0d_fault", i), 64'(ifc.id_fault), 64'(vecs[i].e_fault));
            check($sformatf("vec%0d_imaddr", i), im_addr,          vecs[i].e_im);
        end

        // Randomized traffic against the reference queue
        apply(1, 0, 0, 0, 0);
        mpc = 64'h0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(0, 199) == 0);
            fe  = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       rpc = 64'($urandom_range(0, 4095)) << 2;
                1:       rpc = (64'($urandom_range(0, 4095)) << 2) + 64'($urandom_range(1, 3));
                2:       rpc = 64'h4000 + (64'($urandom_range(0, 255)) << 2);
                default: rpc = {$urandom, $urandom} & ~64'h3;
            endcase

            if (r) begin
                q.delete();
                mpc = 64'h0;
            end else if (rv) begin
                q.delete();
                mpc = rpc;
            end else begin
                pop  = (q.size() != 0) && rdy;
                push = fe && ((q.size() < DEPTH) || pop);
                if (pop)
                    void'(q.pop_front());
                if (push) begin
                    flt     = FAULT_BUILD && ((mpc[1:0] != 2'b00) || (mpc >= 64'h4000));
                    e.pc    = mpc;
                    e.inst  = flt ? NOP : mem_word(mpc);
                    e.fault = flt;
                    q.push_back(e);
                    mpc = mpc + 64'd4;
                end
            end

            apply(r, fe, rv, rpc, rdy);
            check("rnd_valid",  64'(ifc.id_valid), 64'(q.size() != 0));
            check("rnd_pc",     ifc.id_pc,        (q.size() != 0) ? q[0].pc : 64'h0);
            check("rnd_inst",   64'(ifc.id_inst), (q.size() != 0) ? 64'(q[0].inst) : 64'h0);
            check("rnd_fault",  64'(ifc.id_fault), (q.size() != 0) ? 64'(q[0].fault) : 64'h0);
            check("rnd_imaddr", im_addr,          mpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction port of mem64.
- Holds the PC and drives `im_addr` with it. Captures `im_dout` in the same cycle.
- Buffers {pc, inst} pairs in a small FIFO toward decode, using a valid/ready handshake.
- Supports branch/jump redirect with full flush, and an external fetch-enable.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- DEPTH, 2, FIFO entries; power of two, >= 2.
- IMEM_ADDR_BITS, 14, byte-address bits decoded by instruction memory; PC bits above this are out of range.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- fetch_en  input  1  1 = fetching allowed this cycle.
- redirect_valid  input  1  redirect request from execute.
- redirect_pc  input  64  redirect target.
- im_addr  output  64  instruction address to memory; always equals pc.
- im_dout  input  32  instruction word from memory, combinational from im_addr.
- id_valid  output  1  FIFO head valid.
- id_ready  input  1  decode accepts head.
- id_pc  output  64  PC of head entry.
- id_inst  output  32  instruction of head entry.
- id_fault  output  1  fault flag of head entry (see Optional Feature).

Behaviour:
- Reset (rst=1 at posedge):
  - pc <= RESET_PC, FIFO count <= 0, pointers <= 0.
  - After reset: id_valid=0, id_pc/id_inst/id_fault read as 0, im_addr=RESET_PC.
- Internal definitions:
  - pop = id_valid & id_ready.
  - space = (count < DEPTH) | pop.
  - push = fetch_en & space & ~redirect_valid & ~rst.
- Push: writes {pc, im_dout, fault} at the write pointer and sets pc <= pc + 64'd4 (wraps modulo 2^64). Fetch latency: instruction at PC appears on id_* at earliest the cycle after it is addressed.
- Pop: advances the read pointer. Simultaneous push and pop when full is legal; count is unchanged.
- Count rule: count +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Outputs:
  - id_valid = (count != 0).
  - id_pc, id_inst, id_fault come from the head entry. When empty they read as 0.
  - Head data stays stable while id_valid=1 and id_ready=0.
- Redirect (redirect_valid=1 at posedge):
  - Flushes the FIFO (count, pointers <= 0) and sets pc <= redirect_pc.
  - Any pop that cycle is discarded, and no push occurs.
  - Redirect has priority over fetch_en, push and pop; reset has priority over redirect.
  - First instruction from redirect_pc is pushed on the next cycle with fetch_en=1.
- fetch_en=0: no push and pc holds; pops continue normally.
- Full with no pop: no push, pc holds; im_addr stays on the unfetched PC.
- redirect_pc is taken as-is; no alignment forcing.
- Control states (derived from count, no separate FSM register): EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL on push with no pop.
  - FULL -> PARTIAL on pop with no push.
  - PARTIAL -> EMPTY on pop with no push when count=1.
  - Any state -> EMPTY on redirect or reset.

Optional Feature:
- Macro: FETCH_FAULT_EN.
- Defined: fault = (pc[1:0] != 2'b00) | (pc[63:IMEM_ADDR_BITS] != 0), stored per entry.
  - Faulting entries are still pushed, with inst forced to 32'h00000013 (NOP) instead of im_dout.
  - id_fault reflects the head entry.
  - Fetch continues; execute is responsible for raising the trap.
- Not defined: no fault storage; id_fault tied to 0; im_dout is always stored unmodified.

Test Plan:
- Reset then fetch_en=1, id_ready=1, memory words 0..3 = 32'h00000093, 32'h00100113, 32'h00200193, 32'h00300213 -> from cycle 1 after reset, id_pc = 0, 4, 8, 12 on consecutive cycles with matching id_inst; id_valid=1 continuous.
- id_ready=0 for 5 cycles from reset with fetch_en=1 -> FIFO fills after 2 pushes; im_addr holds at 64'h8; id_pc stays 0. Raise id_ready -> pc 0, 4, 8 delivered in order, nothing dropped or duplicated.
- Redirect while full: redirect_valid=1, redirect_pc=64'h40 -> next cycle id_valid=0 and im_addr=64'h40; following cycle id_pc=64'h40 with id_inst = mem word 16.
- Simultaneous redirect and pop with id_ready=1 -> popped entry discarded, count=0; no stale PC (e.g. 64'h4) ever appears after the redirect.
- fetch_en=0 for 3 cycles mid-stream, id_ready=1 -> FIFO drains to id_valid=0; pc holds; resume fetches from the held PC.
- FETCH_FAULT_EN defined: redirect_pc=64'h4002 -> entry has id_fault=1 and id_inst=32'h00000013. Redirect_pc=64'h10 -> id_fault=0. Macro undefined: same stimulus gives id_fault=0 always.
